cic_decim_param: RTL and testbench
==================================

Name: cic_decim_param

Overview:
- Parametrised CIC decimator; next generation of the fixed-order CIC3 filter behind the sigma-delta modulator.
- Consumes the 1-bit modulator bitstream and produces unsigned decimated PCM words.
- Order is a compile-time parameter; decimation ratio R = 2^dec_log2 is runtime-selectable.
- Output is gain-normalised, so full scale is identical at every ratio; sits between sdm_rnm and downstream DSP.

Parameters:
ORDER, 3, number of integrator/comb stages (1..5)
MAX_LOG2, 5, log2 of largest decimation ratio (R_max = 32)
MIN_LOG2, 2, log2 of smallest supported decimation ratio
OUT_W, ORDER*MAX_LOG2+1, output/accumulator width (derived, not overridden)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
in  input  1  modulator bit; 1 maps to +1, 0 maps to 0 (unipolar)
in_valid  input  1  qualifies in; stages advance only when high
dec_log2  input  $clog2(MAX_LOG2+1)  decimation select; values are clamped to [MIN_LOG2, MAX_LOG2]
out  output  OUT_W  decimated sample, unsigned, normalised
out_valid  output  1  one-cycle strobe, new out
busy_settle  output  1  high while warm-up outputs are suppressed

Behaviour:
- Reset: integrators, comb delays, decimation counter and out are cleared; out_valid=0; busy_settle=1; the active ratio loads the clamped dec_log2.
- Integrators: ORDER cascaded stages, each OUT_W wide, with modular wrap-around (overflow is legal). They update only on cycles with in_valid=1.
- Decimation counter: counts accepted inputs 0..R-1. The beat at count R-1 is the decimation tick; the counter then wraps to 0.
- Comb chain: on each tick, ORDER differentiators with delay 1 (at the decimated rate) run on the last integrator value. Arithmetic is modular, OUT_W wide.
- Output update: on the cycle after a tick, out <= comb_result << (ORDER*(MAX_LOG2-L)), where L is the active dec_log2.
  - Full scale (all ones) therefore gives 2^(ORDER*MAX_LOG2) at every L.
  - Latency: out_valid is high exactly one cycle, the cycle after the in_valid beat that completes the tick.
- Warm-up: the first ORDER-1 ticks after reset or after a flush update no output; out_valid stays 0 and busy_settle stays 1.
  - Tick number ORDER is the first valid output; busy_settle falls in that same cycle.
- Ratio change: when the clamped dec_log2 differs from the active L at any clock, a flush occurs the next cycle.
  - Flush: all integrators, comb delays and the counter are cleared synchronously, L is reloaded, warm-up restarts, and out holds its last value.
  - An input beat coincident with the flush cycle is discarded.
- in_valid gaps: the output sequence is identical to gap-free input, only stretched in time.
- out holds its value between strobes.

Optional Feature:
CIC_OUT_FIFO_EN
- Defined:
  - Adds port out_ready (input, 1) and sticky overrun (output, 1, cleared only by reset).
  - out/out_valid become the head of a 4-entry FIFO using a valid/ready handshake; a word pops when out_valid and out_ready are both high.
  - A tick with the FIFO full drops the new sample and sets overrun.
  - A flush does not clear the FIFO.
- Undefined: no extra ports; out_valid is the single-cycle strobe described above, with no back-pressure.

Decomposition:
- Package cic_pkg:
  - function cic_out_w(order, max_log2);
  - localparams for ORDER limits;
  - typedef cic_acc_t sized by cic_out_w;
  - FIFO depth constant CIC_FIFO_DEPTH=4.
- Sub-module cic_comb_stage: one differentiator with a tick enable and synchronous clear, instantiated ORDER times via generate.
- Integrators stay inline in the top module.

Test Plan:
- ORDER=3, dec_log2=5, in constant 1 -> first out_valid after 96 accepted beats, out=32768; every later sample is 32768.
- dec_log2=5, in constant 0 -> out=0; alternating 1/0 -> out=16384 after warm-up.
- dec_log2=3, in constant 1 -> first valid after 24 beats; raw result 512 shifted by 6 gives out=32768.
- Switch dec_log2 5->3 mid-stream -> flush, busy_settle rises, next valid after 24 new beats with correct value; dec_log2=7 clamps to 5 and dec_log2=1 clamps to 2.
- Random in_valid duty 30% with a pseudo-random bitstream -> out sequence equals the golden model's gap-free sequence; assert reset_n mid-tick -> all outputs return to reset values asynchronously.
- With CIC_OUT_FIFO_EN, hold out_ready=0 across 5 ticks -> 4 words are retained, overrun=1, and the words pop in order once ready rises.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared sizing helpers and constants for the parametrised CIC decimator.
package cic_pkg;

    localparam int CIC_ORDER_MIN    = 1;
    localparam int CIC_ORDER_MAX    = 5;
    localparam int CIC_ORDER_DEF    = 3;
    localparam int CIC_MAX_LOG2_DEF = 5;
    localparam int CIC_FIFO_DEPTH   = 4;

    // Full-scale growth is R_max^ORDER; one extra bit keeps that value representable.
    function automatic int cic_out_w(input int order, input int max_log2);
        return order * max_log2 + 1;
    endfunction

    typedef logic [cic_out_w(CIC_ORDER_DEF, CIC_MAX_LOG2_DEF)-1:0] cic_acc_t;

endpackage

// File: rtl/cic_decim_comb.sv
// One CIC differentiator running at the decimated rate: y = x - x(previous tick).
module cic_comb_stage #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         tick_i,
    input  logic         clr_i,
    input  logic [W-1:0] x_i,
    output logic [W-1:0] y_o
);

    logic [W-1:0] dly_q, dly_d;

    always_comb begin
        dly_d = dly_q;
        if (clr_i)       dly_d = '0;
        else if (tick_i) dly_d = x_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) dly_q <= '0;
        else         dly_q <= dly_d;
    end

    assign y_o = x_i - dly_q;

endmodule

// File: rtl/cic_decim_param.sv
// Parametrised CIC decimator, R = 2^L selectable at run time, gain-normalised output.
// Define CIC_OUT_FIFO_EN for a 4-deep valid/ready output FIFO with sticky overrun.
module cic_decim_param
    import cic_pkg::*;
#(
    parameter  int ORDER    = 3,
    parameter  int MAX_LOG2 = 5,
    parameter  int MIN_LOG2 = 2,
    localparam int OUT_W    = cic_out_w(ORDER, MAX_LOG2),
    localparam int DW       = $clog2(MAX_LOG2 + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in,
    input  logic             in_valid,
    input  logic [DW-1:0]    dec_log2,
`ifdef CIC_OUT_FIFO_EN
    input  logic             out_ready,
    output logic             overrun,
`endif
    output logic [OUT_W-1:0] out,
    output logic             out_valid,
    output logic             busy_settle
);

    localparam logic [2:0] WU_LAST = 3'(ORDER - 1);

    function automatic logic [DW-1:0] clamp_l(input logic [DW-1:0] v);
        if (v < DW'(MIN_LOG2)) return DW'(MIN_LOG2);
        if (v > DW'(MAX_LOG2)) return DW'(MAX_LOG2);
        return v;
    endfunction

    logic [DW-1:0]               l_q, l_d, l_clamp, l_act;
    logic                        ld_q, flush_q, flush_d;
    logic [MAX_LOG2-1:0]         cnt_q, cnt_d, rmask;
    logic [ORDER-1:0][OUT_W-1:0] integ_q, integ_d, integ_sum;
    logic [OUT_W-1:0]            acc;
    logic [OUT_W-1:0]            comb_x [ORDER+1];
    logic [2:0]                  wu_q, wu_d;
    logic                        busy_q, busy_d;
    logic                        tick, strobe;
    logic [OUT_W-1:0]            sample;

    // The first cycle after reset adopts the input ratio directly instead of flushing.
    assign l_clamp = clamp_l(dec_log2);
    assign l_act   = ld_q ? l_clamp : l_q;
    assign rmask   = ~({MAX_LOG2{1'b1}} << l_act);
    assign tick    = in_valid && !flush_q && (cnt_q == rmask);

    always_comb begin
        acc = {{(OUT_W-1){1'b0}}, in};
        integ_sum = integ_q;
        for (int k = 0; k < ORDER; k++) begin
            integ_sum[k] = integ_q[k] + acc;
            acc          = integ_sum[k];
        end
    end

    assign comb_x[0] = integ_sum[ORDER-1];

    for (genvar g = 0; g < ORDER; g++) begin : g_comb
        cic_comb_stage #(.W(OUT_W)) u_comb (
            .clk_i  (clk),
            .rst_ni (reset_n),
            .tick_i (tick),
            .clr_i  (flush_q),
            .x_i    (comb_x[g]),
            .y_o    (comb_x[g+1])
        );
    end

    // Scaling by R_max/R per stage makes full scale independent of L.
    assign sample = comb_x[ORDER] << (ORDER * (MAX_LOG2 - int'(l_act)));

    always_comb begin
        l_d     = ld_q ? l_clamp : l_q;
        flush_d = 1'b0;
        cnt_d   = cnt_q;
        integ_d = integ_q;
        wu_d    = wu_q;
        busy_d  = busy_q;
        strobe  = 1'b0;
        if (flush_q) begin
            l_d     = l_clamp;
            cnt_d   = '0;
            integ_d = '0;
            wu_d    = '0;
            busy_d  = 1'b1;
        end else begin
            flush_d = !ld_q && (l_clamp != l_q);
            if (in_valid) begin
                integ_d = integ_sum;
                cnt_d   = tick ? '0 : cnt_q + 1'b1;
            end
            if (tick) begin
                if (wu_q == WU_LAST) begin
                    strobe = 1'b1;
                    busy_d = 1'b0;
                end else begin
                    wu_d = wu_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            l_q     <= DW'(MAX_LOG2);
            ld_q    <= 1'b1;
            flush_q <= 1'b0;
            cnt_q   <= '0;
            integ_q <= '0;
            wu_q    <= '0;
            busy_q  <= 1'b1;
        end else begin
            l_q     <= l_d;
            ld_q    <= 1'b0;
            flush_q <= flush_d;
            cnt_q   <= cnt_d;
            integ_q <= integ_d;
            wu_q    <= wu_d;
            busy_q  <= busy_d;
        end
    end

    assign busy_settle = busy_q;

`ifdef CIC_OUT_FIFO_EN
    localparam int PW = $clog2(CIC_FIFO_DEPTH);

    logic [CIC_FIFO_DEPTH-1:0][OUT_W-1:0] mem_q;
    logic [PW-1:0]                        wr_q, rd_q;
    logic [PW:0]                          fcnt_q;
    logic                                 ovr_q, push, pop;

    assign pop  = (fcnt_q != '0) && out_ready;
    assign push = strobe && (fcnt_q != (PW+1)'(CIC_FIFO_DEPTH));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q  <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            fcnt_q <= '0;
            ovr_q  <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= sample;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            fcnt_q <= fcnt_q + (PW+1)'(push) - (PW+1)'(pop);
            if (strobe && !push) ovr_q <= 1'b1;
        end
    end

    assign out       = mem_q[rd_q];
    assign out_valid = (fcnt_q != '0);
    assign overrun   = ovr_q;
`else
    logic [OUT_W-1:0] out_q;
    logic             vld_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= strobe;
            if (strobe) out_q <= sample;
        end
    end

    assign out       = out_q;
    assign out_valid = vld_q;
`endif

endmodule

// File: tb/tb_cic_decim_param.sv
// Scoreboard bench for cic_decim_param: expected samples come from a direct FIR
// evaluation of the CIC impulse response over the accepted bitstream.
module tb_cic_decim_param;

    localparam int ORD = 3;
    localparam int MXL = 5;
    localparam int MNL = 2;
    localparam int OW  = ORD * MXL + 1;
    localparam int DW  = $clog2(MXL + 1);

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] dec_log2 = DW'(5);
    logic [OW-1:0] out;
    logic          out_valid;
    logic          busy_settle;
`ifdef CIC_OUT_FIFO_EN
    logic          out_ready = 1'b1;
    logic          overrun;
`endif

    cic_decim_param #(.ORDER(ORD), .MAX_LOG2(MXL), .MIN_LOG2(MNL)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in          (in),
        .in_valid    (in_valid),
        .dec_log2    (dec_log2),
`ifdef CIC_OUT_FIFO_EN
        .out_ready   (out_ready),
        .overrun     (overrun),
`endif
        .out         (out),
        .out_valid   (out_valid),
        .busy_settle (busy_settle)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e_m;
    int   checks = 0, fails = 0, n_exp = 0, n_got = 0;
    bit   hold = 1'b0;
    int   held = 0;

    bit   xs[$];
    int   nb, rr, ll, hlen;
    int   h[256];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            fails++;
            $display("FAIL %s got=%0d expected=%0d", nm, got, exp_v);
        end
    endtask

    // Impulse response of ((1 - z^-r) / (1 - z^-1))^ORD: ORD cascaded length-r boxcars.
    function automatic void build_h(input int r);
        int t[256];
        h = '{default: 0};
        h[0] = 1;
        hlen = 1;
        for (int s = 0; s < ORD; s++) begin
            for (int i = 0; i < hlen + r - 1; i++) begin
                t[i] = 0;
                for (int j = 0; j < r; j++)
                    if (i - j >= 0 && i - j < hlen) t[i] += h[i - j];
            end
            hlen += r - 1;
            for (int i = 0; i < hlen; i++) h[i] = t[i];
        end
    endfunction

    function automatic void model_flush(input int d);
        ll = (d < MNL) ? MNL : (d > MXL) ? MXL : d;
        rr = 1 << ll;
        xs.delete();
        nb = 0;
        build_h(rr);
    endfunction

    task automatic beat(input bit b);
        int y;
        exp_t e;
        in = b;
        in_valid = 1'b1;
        xs.push_back(b);
        nb++;
        if (nb % rr == 0 && nb / rr >= ORD) begin
            y = 0;
            for (int j = 0; j < hlen; j++)
                if (nb - 1 - j >= 0) y += h[j] * int'(xs[nb - 1 - j]);
            e.val = (y << (ORD * (MXL - ll))) & ((1 << OW) - 1);
            if (!hold) begin
                e.cyc = cyc + 1;
                sb.push_back(e);
                n_exp++;
            end else if (held < 4) begin
                e.cyc = -1;
                sb.push_back(e);
                n_exp++;
                held++;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            in = 1'($urandom_range(1));
            @(negedge clk);
        end
    endtask

    // A handshake seen at a falling edge is the word consumed at the next rising edge.
    always @(negedge clk) begin
`ifdef CIC_OUT_FIFO_EN
        if (reset_n && out_valid && out_ready) begin
`else
        if (reset_n && out_valid) begin
`endif
            n_got++;
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_sample got=%0d at_cycle=%0d", out, cyc);
            end else begin
                e_m = sb.pop_front();
                if (out !== OW'(e_m.val) || (e_m.cyc >= 0 && e_m.cyc != cyc)) begin
                    fails++;
                    $display("FAIL sample got=%0d at_cycle=%0d expected=%0d at_cycle=%0d",
                             out, cyc, e_m.val, e_m.cyc);
                end
            end
        end
    end

    initial begin
        reset_n = 1'b1;
        model_flush(5);
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_out", 32'(out), 0);
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_busy", 32'(busy_settle), 1);
`ifdef CIC_OUT_FIFO_EN
        chk("reset_overrun", 32'(overrun), 0);
`endif
        reset_n = 1'b1;

        // R=32, all ones: first sample after 96 beats, full scale every tick.
        repeat (95) beat(1'b1);
        chk("busy_before_first_sample", 32'(busy_settle), 1);
        repeat (65) beat(1'b1);
        chk("busy_after_warmup", 32'(busy_settle), 0);

        repeat (96) beat(1'b0);
        for (int i = 0; i < 128; i++) beat(1'(i % 2 == 0));

        // 7 clamps to the active 5: no flush, output cadence continues.
        dec_log2 = DW'(7);
        repeat (32) beat(1'b1);
        chk("busy_clamp_high_no_flush", 32'(busy_settle), 0);

        dec_log2 = DW'(3);
        idle(3);
        model_flush(3);
        chk("busy_after_flush_r8", 32'(busy_settle), 1);
        repeat (40) beat(1'b1);
        chk("busy_settled_r8", 32'(busy_settle), 0);

        // 1 clamps to 2, which differs from 3: flush to R=4.
        dec_log2 = DW'(1);
        idle(3);
        model_flush(1);
        chk("busy_after_flush_r4", 32'(busy_settle), 1);
        repeat (24) beat(1'b1);

        dec_log2 = DW'(5);
        idle(3);
        model_flush(5);
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(99) < 30) beat(1'($urandom_range(1)));
            else idle(1);
        end
        idle(2);
        chk("drained_before_reset", 32'(sb.size()), 0);

        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_out", 32'(out), 0);
        chk("async_reset_out_valid", 32'(out_valid), 0);
        chk("async_reset_busy", 32'(busy_settle), 1);
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        model_flush(5);
        repeat (96) beat(1'b1);

`ifdef CIC_OUT_FIFO_EN
        @(posedge clk);
        #1 out_ready = 1'b0;
        hold = 1'b1;
        held = 0;
        @(negedge clk);
        repeat (160) beat(1'($urandom_range(1)));
        chk("fifo_overrun", 32'(overrun), 1);
        chk("fifo_head_valid", 32'(out_valid), 1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        hold = 1'b0;
        @(negedge clk);
        idle(6);
        chk("fifo_overrun_sticky", 32'(overrun), 1);
`endif

        idle(4);
        chk("scoreboard_empty", 32'(sb.size()), 0);
        chk("sample_count", 32'(n_got), 32'(n_exp));
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
